// File: rtl/tx_frame_scheduler_if.sv
// Bus bundle between the frame scheduler and its sources, UART and status observers.
// The scheduler takes the slave side; whoever drives the sources and acks takes master.
interface tx_frame_scheduler_if;
  logic [7:0] game_state_data;
  logic [7:0] target_data;
  logic [7:0] operate_data;
  logic       data_ready;
  logic [7:0] data_send;
  logic       busy;
  logic [2:0] pending;
  logic       timeout_err;
  logic [7:0] sent_count;

  modport slave (
    input  game_state_data, target_data, operate_data, data_ready,
    output data_send, busy, pending, timeout_err, sent_count
  );

  modport master (
    output game_state_data, target_data, operate_data, data_ready,
    input  data_send, busy, pending, timeout_err, sent_count
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Serialises three byte sources onto one UART input with change-driven priority scheduling,
// per-byte acknowledge, SEND timeout with resend, and periodic keep-alive refresh.
module tx_frame_scheduler #(
  parameter logic [7:0]  IDLE_BYTE      = 8'h00,
  parameter logic [15:0] REFRESH_CYCLES = 16'd15360,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input logic             clock,
  input logic             reset,
  tx_frame_scheduler_if.slave bus
);

  localparam int unsigned DW   = 8;
  localparam int unsigned NSRC = 3;
  localparam int unsigned CW   = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [DW-1:0]             data_q, data_d;
  logic [NSRC-1:0]           sel_q, sel_d;
  logic [NSRC-1:0]           pending_q, pending_d;
  logic [NSRC-1:0][DW-1:0]   shadow_q;
  logic [DW-1:0]             count_q, count_d;
  logic                      err_q, err_d;
  logic [CW-1:0]             dwell_q, dwell_d;
  logic [CW-1:0]             refresh_q, refresh_d;
  logic                      armed_q;

  logic [NSRC-1:0][DW-1:0]   src;
  logic [NSRC-1:0]           chg;
  logic [NSRC-1:0]           pend_set;
  logic [NSRC-1:0]           pend_clr;

  assign src = {bus.operate_data, bus.target_data, bus.game_state_data};

  // Shadows hold reset values on the first cycle after reset; pending is already all-ones
  // then, so change detection is held off until the shadows have captured real inputs.
  always_comb begin
    chg = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      chg[i] = armed_q && (src[i] != shadow_q[i]);
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    count_d   = count_q;
    err_d     = err_q;
    dwell_d   = dwell_q;
    refresh_d = '0;
    pend_set  = '0;
    pend_clr  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = S_SEND;
          dwell_d = '0;
          if (pending_q[0]) begin
            sel_d  = 3'b001;
            data_d = src[0];
          end else if (pending_q[1]) begin
            sel_d  = 3'b010;
            data_d = src[1];
          end else begin
            sel_d  = 3'b100;
            data_d = src[2];
          end
          pend_clr = sel_d;
        end else if (refresh_q == REFRESH_CYCLES - CW'(1)) begin
          pend_set = '1;
        end else begin
          refresh_d = refresh_q + CW'(1);
        end
      end
      S_SEND: begin
        if (bus.data_ready) begin
          count_d = count_q + DW'(1);
          state_d = S_IDLE;
          data_d  = IDLE_BYTE;
        end else if (dwell_q == TIMEOUT_CYCLES - CW'(1)) begin
          err_d    = 1'b1;
          pend_set = sel_q;
          state_d  = S_IDLE;
          data_d   = IDLE_BYTE;
        end else begin
          dwell_d = dwell_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A change landing on the same edge as the clear keeps the bit set.
    pending_d = (pending_q & ~pend_clr) | pend_set | chg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= IDLE_BYTE;
      sel_q     <= '0;
      pending_q <= '1;
      shadow_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      dwell_q   <= '0;
      refresh_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      shadow_q  <= src;
      count_q   <= count_d;
      err_q     <= err_d;
      dwell_q   <= dwell_d;
      refresh_q <= refresh_d;
      armed_q   <= 1'b1;
    end
  end

  assign bus.data_send   = data_q;
  assign bus.busy        = (state_q == S_SEND);
  assign bus.pending     = pending_q;
  assign bus.timeout_err = err_q;
  assign bus.sent_count  = count_q;

endmodule
